iir_coeff_ctrl: RTL
===================

# iir_coeff_ctrl

Sequencer and configuration front-end for the two-channel 3-tap IIR audio filter when the filter runs with `use_params = 0`. It generates the filter's `ce` (channel-interleaved rate) and `sample_ce` strobes from the system clock with a fractional divider. It holds a host-writable shadow coefficient bank and applies it atomically at a sample boundary, then flushes the filter state and mutes the output while the flushed filter settles.

## Interface
- `CLK_HZ`, 74250000: system clock frequency in Hz. Must be ≥ 2·`SAMPLE_HZ`·(`STEREO`+1).
- `SAMPLE_HZ`, 48000: output sample rate in Hz.
- `STEREO`, 1: 1 makes `ce` run at 2× the sample rate; 0 is mono (`ce` = `sample_ce`).
- `MUTE_SAMPLES`, 64: number of `sample_ce` periods `mute` stays high after an apply. Range 1..65535.
- `clk`  in  1  system clock. One clock domain. Reset is synchronous and active-low.
- `reset_n`  in  1  synchronous active-low reset.
- `wr_en`  in  1  host write strobe, one write per cycle.
- `wr_addr`  in  3  register select.
- `wr_data`  in  32  write data.
- `ce`  out  1  filter tick, single-cycle pulse.
- `sample_ce`  out  1  output-sample tick, single-cycle pulse.
- `cx`  out  40  active base gain.
- `cx0`, `cx1`, `cx2`  out  8 each  active integer gain scales.
- `cy0`, `cy1`, `cy2`  out  24 each  active feedback coefficients.
- `flt_reset`  out  1  active-high filter state clear.
- `mute`  out  1  downstream mixer silences the filter output while high.
- `cfg_pending`  out  1  a commit is waiting for a sample boundary.

## Operation
- Register map (write-only; all writes go to the shadow bank):
  - 0: `cx[31:0]`
  - 1: `cx[39:32]` = `wr_data[7:0]`
  - 2: {`cx2`, `cx1`, `cx0`} = `wr_data[23:0]`
  - 3: `cy0` = `wr_data[23:0]`
  - 4: `cy1` = `wr_data[23:0]`
  - 5: `cy2` = `wr_data[23:0]`
  - 6: commit when `wr_data[0]` = 1
  - 7: reserved, ignored.
- Unused data bits are ignored.
- Divider: 32-bit accumulator `acc`, increment INC = `SAMPLE_HZ`·(`STEREO`+1).
  - Each cycle, if `acc`+INC ≥ `CLK_HZ`: `ce` = 1 and `acc` ← `acc`+INC−`CLK_HZ`.
  - Otherwise `ce` = 0 and `acc` ← `acc`+INC.
- Pair bit `ph` toggles on every `ce` (stereo only).
  - `sample_ce` = `ce` & `ph` when stereo, i.e. on the second `ce` of each pair.
  - `sample_ce` = `ce` when mono.
- States:
  - **IDLE**: commit → PENDING.
  - **PENDING**: `cfg_pending` = 1. On a cycle with `sample_ce` → APPLY.
  - **APPLY**: one cycle. Active ← shadow, `flt_reset` = 1, mute counter ← `MUTE_SAMPLES` → MUTE.
  - **MUTE**: counter decrements on each `sample_ce`. When it reaches 0 → PENDING if `req_latched`, otherwise → IDLE.
- A commit in PENDING is a no-op.
- A commit in APPLY or MUTE sets `req_latched`, which is cleared on leaving MUTE.
- Shadow writes are accepted in every state.
  - A write in the same cycle as the APPLY copy is not included in that apply; it is held for the next commit.
- `mute` = 1 in APPLY and MUTE, and from reset until the first APPLY completes its MUTE period.
- `ce` generation is never stalled by the state machine.

## Timing
- Reset (`reset_n` = 0 at a clock edge) sets:
  - `acc` = 0, `ph` = 0, state IDLE, `req_latched` = 0
  - shadow and active coefficients = 0
  - `ce` = `sample_ce` = `flt_reset` = `cfg_pending` = 0, `mute` = 1
- Reset mid-operation drops any pending commit and in-flight mute count.
- `ce` and `sample_ce` are registered: high for exactly one cycle, in the cycle after the accumulator compare.
- Commit latency: `cfg_pending` rises the cycle after the commit write.
- The APPLY cycle is the cycle after the `sample_ce` pulse. The new coefficients and `flt_reset` = 1 appear together in that cycle.
- `mute` falls the cycle after the `MUTE_SAMPLES`-th `sample_ce` following APPLY.
- A commit write in the same cycle as a PENDING-state `sample_ce` is a no-op (already pending).

## Structure
- Package `iir_ctrl_pkg` holds:
  - register address localparams (`ADDR_CX_LO` … `ADDR_COMMIT`)
  - the state enum `{IDLE, PENDING, APPLY, MUTE}`
  - coefficient width localparams (40/8/24).
- Sub-module `ce_frac_div` (parameters `CLK_HZ`, INC; outputs a registered strobe) implements the accumulator.
- `iir_coeff_ctrl` contains the pair bit, shadow/active banks and the FSM.

## Test plan
- `CLK_HZ` = 12, `SAMPLE_HZ` = 1, `STEREO` = 1, released from reset → `ce` every 6 cycles, `sample_ce` every 12 cycles on alternate `ce`s; `mute` = 1 throughout.
- `CLK_HZ` = 10, `SAMPLE_HZ` = 3, mono → `ce` = `sample_ce`, with inter-pulse gaps following the pattern 4,3,3 (10 clocks per 3 pulses).
- Write `cx` = 40'h00_0040_FC1A, `cy0` = 24'hA11C3B, then commit → outputs unchanged until the next `sample_ce`. On the following cycle `cx`/`cy0` update and `flt_reset` pulses once. With `MUTE_SAMPLES` = 4, `mute` stays high for 4 `sample_ce`s after APPLY.
- Commit during MUTE, then rewrite `cy1` = 24'h5DBE77 → after MUTE ends, the FSM re-enters PENDING and applies with the new `cy1` at the next `sample_ce`.
- Write `cy2` in the APPLY cycle → active `cy2` keeps the pre-write value; a later commit applies it.
- Assert `reset_n` = 0 in PENDING and in MUTE → next cycle all coefficients = 0, `cfg_pending` = 0, `mute` = 1, and no `flt_reset` pulse occurs.

Source files
------------

// File: rtl/iir_ctrl_pkg.sv
// Shared definitions for the IIR coefficient sequencer: register map, FSM states
// and the coefficient bank layout used for both the shadow and active copies.
package iir_ctrl_pkg;

  localparam int CX_W  = 40;
  localparam int CXN_W = 8;
  localparam int CY_W  = 24;

  localparam logic [2:0] ADDR_CX_LO  = 3'd0;
  localparam logic [2:0] ADDR_CX_HI  = 3'd1;
  localparam logic [2:0] ADDR_CXN    = 3'd2;
  localparam logic [2:0] ADDR_CY0    = 3'd3;
  localparam logic [2:0] ADDR_CY1    = 3'd4;
  localparam logic [2:0] ADDR_CY2    = 3'd5;
  localparam logic [2:0] ADDR_COMMIT = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    APPLY,
    MUTE
  } ctrl_state_t;

  typedef struct packed {
    logic [CX_W-1:0]  cx;
    logic [CXN_W-1:0] cx2;
    logic [CXN_W-1:0] cx1;
    logic [CXN_W-1:0] cx0;
    logic [CY_W-1:0]  cy0;
    logic [CY_W-1:0]  cy1;
    logic [CY_W-1:0]  cy2;
  } coef_bank_t;

endpackage

// File: rtl/ce_frac_div.sv
// Fractional clock-enable divider: adds INC per clock and emits a one-cycle
// registered strobe each time the accumulator wraps past CLK_HZ.
module ce_frac_div #(
  parameter int unsigned CLK_HZ = 74250000,
  parameter int unsigned INC    = 96000
) (
  input  logic clk,
  input  logic reset_n,
  output logic o_fire,
  output logic o_strobe
);

  localparam logic [32:0] L_CLK = 33'(CLK_HZ);
  localparam logic [32:0] L_INC = 33'(INC);

  logic [31:0] r_acc;
  logic        r_strobe;
  logic [32:0] w_sum;
  logic        w_fire;

  // 33-bit sum so the compare never wraps, even near the top of the range
  assign w_sum  = {1'b0, r_acc} + L_INC;
  assign w_fire = (w_sum >= L_CLK);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc    <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_fire;
      r_acc    <= w_fire ? 32'(w_sum - L_CLK) : w_sum[31:0];
    end
  end

  assign o_fire   = w_fire;
  assign o_strobe = r_strobe;

endmodule

// File: rtl/iir_coeff_ctrl.sv
// Sequencer/config front-end for the 2-channel 3-tap IIR: ce/sample_ce generation,
// shadow coefficient bank with sample-aligned atomic apply, flush and mute.
module iir_coeff_ctrl
  import iir_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 74250000,
  parameter int unsigned SAMPLE_HZ    = 48000,
  parameter int unsigned STEREO       = 1,
  parameter int unsigned MUTE_SAMPLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        ce,
  output logic        sample_ce,
  output logic [39:0] cx,
  output logic [7:0]  cx0,
  output logic [7:0]  cx1,
  output logic [7:0]  cx2,
  output logic [23:0] cy0,
  output logic [23:0] cy1,
  output logic [23:0] cy2,
  output logic        flt_reset,
  output logic        mute,
  output logic        cfg_pending
);

  localparam int unsigned L_INC    = SAMPLE_HZ * (STEREO + 1);
  localparam logic        L_STEREO = (STEREO != 0);
  localparam logic [15:0] L_MUTE   = 16'(MUTE_SAMPLES);

  logic        w_fire;
  logic        w_ce;
  logic        w_commit;
  logic        r_ph;
  logic        r_sample_ce;
  coef_bank_t  r_shadow;
  coef_bank_t  r_active;
  ctrl_state_t r_state;
  logic [15:0] r_mcnt;
  logic        r_req;
  logic        r_cfg_pending;
  logic        r_flt_reset;
  logic        r_mute;

  ce_frac_div #(
    .CLK_HZ (CLK_HZ),
    .INC    (L_INC)
  ) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .o_fire   (w_fire),
    .o_strobe (w_ce)
  );

  // Pair bit flips alongside the ce register so sample_ce lands on the 2nd ce of a pair
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ph        <= 1'b0;
      r_sample_ce <= 1'b0;
    end else begin
      if (w_fire) r_ph <= ~r_ph;
      r_sample_ce <= w_fire & (r_ph | ~L_STEREO);
    end
  end

  assign w_commit = wr_en && (wr_addr == ADDR_COMMIT) && wr_data[0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shadow <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_CX_LO: r_shadow.cx[31:0]  <= wr_data;
        ADDR_CX_HI: r_shadow.cx[39:32] <= wr_data[7:0];
        ADDR_CXN:   {r_shadow.cx2, r_shadow.cx1, r_shadow.cx0} <= wr_data[23:0];
        ADDR_CY0:   r_shadow.cy0 <= wr_data[23:0];
        ADDR_CY1:   r_shadow.cy1 <= wr_data[23:0];
        ADDR_CY2:   r_shadow.cy2 <= wr_data[23:0];
        default:    ;
      endcase
    end
  end

  // Active bank is loaded on entry to APPLY, so it reads the shadow as of that edge;
  // any write landing in the APPLY cycle itself stays in the shadow for later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_req         <= 1'b0;
      r_mcnt        <= '0;
      r_active      <= '0;
      r_cfg_pending <= 1'b0;
      r_flt_reset   <= 1'b0;
      r_mute        <= 1'b1;
    end else begin
      r_flt_reset <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_commit) begin
            r_state       <= PENDING;
            r_cfg_pending <= 1'b1;
          end
        end
        PENDING: begin
          if (r_sample_ce) begin
            r_state       <= APPLY;
            r_cfg_pending <= 1'b0;
            r_flt_reset   <= 1'b1;
            r_mute        <= 1'b1;
            r_active      <= r_shadow;
          end
        end
        APPLY: begin
          r_state <= MUTE;
          r_mcnt  <= L_MUTE;
          if (w_commit) r_req <= 1'b1;
        end
        MUTE: begin
          if (w_commit) r_req <= 1'b1;
          if (r_sample_ce) begin
            if (r_mcnt == 16'd1) begin
              r_req  <= 1'b0;
              r_mute <= 1'b0;
              if (r_req || w_commit) begin
                r_state       <= PENDING;
                r_cfg_pending <= 1'b1;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_mcnt <= r_mcnt - 16'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ce          = w_ce;
  assign sample_ce   = r_sample_ce;
  assign cx          = r_active.cx;
  assign cx0         = r_active.cx0;
  assign cx1         = r_active.cx1;
  assign cx2         = r_active.cx2;
  assign cy0         = r_active.cy0;
  assign cy1         = r_active.cy1;
  assign cy2         = r_active.cy2;
  assign flt_reset   = r_flt_reset;
  assign mute        = r_mute;
  assign cfg_pending = r_cfg_pending;

endmodule
